// File: rtl/me_pkg.sv
// Shared lane geometry, SAD widths and FSM state for the motion-estimation best-MV tracker.
package me_pkg;

  localparam int MV_W_DEF = 6;

  localparam int N_4X8   = 32;
  localparam int N_8X4   = 32;
  localparam int N_8X8   = 16;
  localparam int N_8X16  = 8;
  localparam int N_16X8  = 8;
  localparam int N_16X16 = 4;

  localparam int W_4X8   = 13;
  localparam int W_8X4   = 13;
  localparam int W_8X8   = 14;
  localparam int W_8X16  = 15;
  localparam int W_16X8  = 15;
  localparam int W_16X16 = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/me_best_mv_tracker_if.sv
// Candidate and result bundle of the best-MV tracker; master drives candidates, slave is the tracker.
interface me_best_mv_tracker_if
  import me_pkg::*;
#(
  parameter int MV_W = MV_W_DEF
) ();

  logic                          cu_start;
  logic                          cand_valid;
  logic                          cand_ready;
  logic [MV_W-1:0]               cand_mv_x;
  logic [MV_W-1:0]               cand_mv_y;
  logic [N_4X8*W_4X8-1:0]        SAD4x8;
  logic [N_8X4*W_8X4-1:0]        SAD8x4;
  logic [N_8X8*W_8X8-1:0]        SAD8x8;
  logic [N_8X16*W_8X16-1:0]      SAD8x16;
  logic [N_16X8*W_16X8-1:0]      SAD16x8;
  logic [N_16X16*W_16X16-1:0]    SAD16x16;

  logic                          res_valid;
  logic                          res_ready;
  logic [N_4X8*W_4X8-1:0]        min_SAD4x8;
  logic [N_8X4*W_8X4-1:0]        min_SAD8x4;
  logic [N_8X8*W_8X8-1:0]        min_SAD8x8;
  logic [N_8X16*W_8X16-1:0]      min_SAD8x16;
  logic [N_16X8*W_16X8-1:0]      min_SAD16x8;
  logic [N_16X16*W_16X16-1:0]    min_SAD16x16;
  logic [N_4X8*2*MV_W-1:0]       best_mv4x8;
  logic [N_8X4*2*MV_W-1:0]       best_mv8x4;
  logic [N_8X8*2*MV_W-1:0]       best_mv8x8;
  logic [N_8X16*2*MV_W-1:0]      best_mv8x16;
  logic [N_16X8*2*MV_W-1:0]      best_mv16x8;
  logic [N_16X16*2*MV_W-1:0]     best_mv16x16;

  modport master (
    output cu_start, cand_valid, cand_mv_x, cand_mv_y,
           SAD4x8, SAD8x4, SAD8x8, SAD8x16, SAD16x8, SAD16x16, res_ready,
    input  cand_ready, res_valid,
           min_SAD4x8, min_SAD8x4, min_SAD8x8, min_SAD8x16, min_SAD16x8, min_SAD16x16,
           best_mv4x8, best_mv8x4, best_mv8x8, best_mv8x16, best_mv16x8, best_mv16x16
  );

  modport slave (
    input  cu_start, cand_valid, cand_mv_x, cand_mv_y,
           SAD4x8, SAD8x4, SAD8x8, SAD8x16, SAD16x8, SAD16x16, res_ready,
    output cand_ready, res_valid,
           min_SAD4x8, min_SAD8x4, min_SAD8x8, min_SAD8x16, min_SAD16x8, min_SAD16x16,
           best_mv4x8, best_mv8x4, best_mv8x8, best_mv8x16, best_mv16x8, best_mv16x16
  );

endinterface

// File: rtl/me_min_lane.sv
// One partition lane: holds the smallest SAD seen in the current window and the MV that produced it.
module me_min_lane #(
  parameter int SAD_W = 13,
  parameter int MV_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_first,
  input  logic              upd_en,
  input  logic [SAD_W-1:0]  sad_in,
  input  logic [2*MV_W-1:0] mv_in,
  output logic [SAD_W-1:0]  sad_q,
  output logic [2*MV_W-1:0] mv_q
);

  // Strict less-than so a tie keeps the earlier MV; the first candidate of a window always loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad_q <= '1;
      mv_q  <= '0;
    end else if (load_first || (upd_en && (sad_in < sad_q))) begin
      sad_q <= sad_in;
      mv_q  <= mv_in;
    end
  end

endmodule

// File: rtl/me_best_mv_tracker.sv
// Per-partition minimum-SAD / best-MV tracker over one CU search window, with start/candidate/result FSM.
module me_best_mv_tracker
  import me_pkg::*;
#(
  parameter int MV_W     = MV_W_DEF,
  parameter int NUM_CAND = 1024
) (
  input logic clk,
  input logic rst_n,
  me_best_mv_tracker_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_CAND + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CAND - 1);

  state_t           state;
  logic [CNT_W-1:0] cand_cnt;
  logic             first_flag;
  logic             cand_ready_q;
  logic             res_valid_q;
  logic             accept;
  logic             load_first;
  logic [2*MV_W-1:0] mv_in;

  assign accept     = bus.cand_valid & cand_ready_q;
  assign load_first = accept & first_flag;
  assign mv_in      = {bus.cand_mv_y, bus.cand_mv_x};

  assign bus.cand_ready = cand_ready_q;
  assign bus.res_valid  = res_valid_q;

  // cu_start only matters in IDLE; the last accept of the window moves straight to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cand_cnt     <= '0;
      first_flag   <= 1'b0;
      cand_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cu_start) begin
            state        <= SEARCH;
            cand_cnt     <= '0;
            first_flag   <= 1'b1;
            cand_ready_q <= 1'b1;
          end
        end
        SEARCH: begin
          if (accept) begin
            first_flag <= 1'b0;
            cand_cnt   <= cand_cnt + CNT_W'(1);
            if (cand_cnt == LAST_CNT) begin
              state        <= DONE;
              cand_ready_q <= 1'b0;
              res_valid_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          cand_ready_q <= 1'b0;
          res_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [N_4X8*W_4X8-1:0]       sad_4x8;
  logic [N_8X4*W_8X4-1:0]       sad_8x4;
  logic [N_8X8*W_8X8-1:0]       sad_8x8;
  logic [N_8X16*W_8X16-1:0]     sad_8x16;
  logic [N_16X8*W_16X8-1:0]     sad_16x8;
  logic [N_16X16*W_16X16-1:0]   sad_16x16;
  logic [N_4X8*2*MV_W-1:0]      mv_4x8;
  logic [N_8X4*2*MV_W-1:0]      mv_8x4;
  logic [N_8X8*2*MV_W-1:0]      mv_8x8;
  logic [N_8X16*2*MV_W-1:0]     mv_8x16;
  logic [N_16X8*2*MV_W-1:0]     mv_16x8;
  logic [N_16X16*2*MV_W-1:0]    mv_16x16;

  for (genvar i = 0; i < N_4X8; i++) begin : g_4x8
    me_min_lane #(.SAD_W(W_4X8), .MV_W(MV_W)) u_lane (
      .clk(clk), .rst_n(rst_n), .load_first(load_first), .upd_en(accept),
      .sad_in(bus.SAD4x8[i*W_4X8 +: W_4X8]), .mv_in(mv_in),
      .sad_q(sad_4x8[i*W_4X8 +: W_4X8]), .mv_q(mv_4x8[i*2*MV_W +: 2*MV_W]));
  end

  for (genvar i = 0; i < N_8X4; i++) begin : g_8x4
    me_min_lane #(.SAD_W(W_8X4), .MV_W(MV_W)) u_lane (
      .clk(clk), .rst_n(rst_n), .load_first(load_first), .upd_en(accept),
      .sad_in(bus.SAD8x4[i*W_8X4 +: W_8X4]), .mv_in(mv_in),
      .sad_q(sad_8x4[i*W_8X4 +: W_8X4]), .mv_q(mv_8x4[i*2*MV_W +: 2*MV_W]));
  end

  for (genvar i = 0; i < N_8X8; i++) begin : g_8x8
    me_min_lane #(.SAD_W(W_8X8), .MV_W(MV_W)) u_lane (
      .clk(clk), .rst_n(rst_n), .load_first(load_first), .upd_en(accept),
      .sad_in(bus.SAD8x8[i*W_8X8 +: W_8X8]), .mv_in(mv_in),
      .sad_q(sad_8x8[i*W_8X8 +: W_8X8]), .mv_q(mv_8x8[i*2*MV_W +: 2*MV_W]));
  end

  for (genvar i = 0; i < N_8X16; i++) begin : g_8x16
    me_min_lane #(.SAD_W(W_8X16), .MV_W(MV_W)) u_lane (
      .clk(clk), .rst_n(rst_n), .load_first(load_first), .upd_en(accept),
      .sad_in(bus.SAD8x16[i*W_8X16 +: W_8X16]), .mv_in(mv_in),
      .sad_q(sad_8x16[i*W_8X16 +: W_8X16]), .mv_q(mv_8x16[i*2*MV_W +: 2*MV_W]));
  end

  for (genvar i = 0; i < N_16X8; i++) begin : g_16x8
    me_min_lane #(.SAD_W(W_16X8), .MV_W(MV_W)) u_lane (
      .clk(clk), .rst_n(rst_n), .load_first(load_first), .upd_en(accept),
      .sad_in(bus.SAD16x8[i*W_16X8 +: W_16X8]), .mv_in(mv_in),
      .sad_q(sad_16x8[i*W_16X8 +: W_16X8]), .mv_q(mv_16x8[i*2*MV_W +: 2*MV_W]));
  end

  for (genvar i = 0; i < N_16X16; i++) begin : g_16x16
    me_min_lane #(.SAD_W(W_16X16), .MV_W(MV_W)) u_lane (
      .clk(clk), .rst_n(rst_n), .load_first(load_first), .upd_en(accept),
      .sad_in(bus.SAD16x16[i*W_16X16 +: W_16X16]), .mv_in(mv_in),
      .sad_q(sad_16x16[i*W_16X16 +: W_16X16]), .mv_q(mv_16x16[i*2*MV_W +: 2*MV_W]));
  end

  assign bus.min_SAD4x8   = sad_4x8;
  assign bus.min_SAD8x4   = sad_8x4;
  assign bus.min_SAD8x8   = sad_8x8;
  assign bus.min_SAD8x16  = sad_8x16;
  assign bus.min_SAD16x8  = sad_16x8;
  assign bus.min_SAD16x16 = sad_16x16;
  assign bus.best_mv4x8   = mv_4x8;
  assign bus.best_mv8x4   = mv_8x4;
  assign bus.best_mv8x8   = mv_8x8;
  assign bus.best_mv8x16  = mv_8x16;
  assign bus.best_mv16x8  = mv_16x8;
  assign bus.best_mv16x16 = mv_16x16;

endmodule

// File: tb/tb_me_best_mv_tracker.sv
// Bench for me_best_mv_tracker: directed and randomized search windows checked against a first-argmin model.
module tb_me_best_mv_tracker;

  localparam int MVW = 6;
  localparam int NC  = 4;
  localparam int NL  = 100;
  localparam int S_IDLE = 0, S_SEARCH = 1, S_DONE = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  me_best_mv_tracker_if #(.MV_W(MVW)) bus ();
  me_best_mv_tracker #(.MV_W(MVW), .NUM_CAND(NC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int exp_state;
  int hist_n;
  logic [15:0]      in_sad   [NL];
  logic [15:0]      hist_sad [NC][NL];
  logic [2*MVW-1:0] hist_mv  [NC];
  logic [15:0]      exp_sad  [NL];
  logic [2*MVW-1:0] exp_mv   [NL];
  int               mono_sad [4] = '{100, 80, 90, 80};
  logic [MVW-1:0]   mono_x   [4] = '{6'd0, 6'd1, 6'd2, 6'd3};
  logic [MVW-1:0]   mono_y   [4] = '{6'd0, 6'h3F, 6'd2, 6'd3};
  logic [MVW-1:0]   rx, ry;
  logic [2*MVW-1:0] mv_c2, mv_c3;
  int               guard;

  // Lanes are numbered 0..99 across 4x8, 8x4, 8x8, 8x16, 16x8, 16x16 in that order.
  function automatic int lane_w(int k);
    if (k < 64) return 13;
    if (k < 80) return 14;
    if (k < 96) return 15;
    return 16;
  endfunction

  function automatic int lane_i(int k);
    if (k < 32) return k;
    if (k < 64) return k - 32;
    if (k < 80) return k - 64;
    if (k < 88) return k - 80;
    if (k < 96) return k - 88;
    return k - 96;
  endfunction

  function automatic logic [15:0] all_ones(int k);
    return 16'((32'd1 << lane_w(k)) - 32'd1);
  endfunction

  function automatic logic [15:0] obs_sad(int k);
    int i = lane_i(k);
    if (k < 32) return 16'(bus.min_SAD4x8[i*13 +: 13]);
    if (k < 64) return 16'(bus.min_SAD8x4[i*13 +: 13]);
    if (k < 80) return 16'(bus.min_SAD8x8[i*14 +: 14]);
    if (k < 88) return 16'(bus.min_SAD8x16[i*15 +: 15]);
    if (k < 96) return 16'(bus.min_SAD16x8[i*15 +: 15]);
    return bus.min_SAD16x16[i*16 +: 16];
  endfunction

  function automatic logic [2*MVW-1:0] obs_mv(int k);
    int i = lane_i(k);
    if (k < 32) return bus.best_mv4x8[i*2*MVW +: 2*MVW];
    if (k < 64) return bus.best_mv8x4[i*2*MVW +: 2*MVW];
    if (k < 80) return bus.best_mv8x8[i*2*MVW +: 2*MVW];
    if (k < 88) return bus.best_mv8x16[i*2*MVW +: 2*MVW];
    if (k < 96) return bus.best_mv16x8[i*2*MVW +: 2*MVW];
    return bus.best_mv16x16[i*2*MVW +: 2*MVW];
  endfunction

  task automatic drive_sads();
    for (int k = 0; k < NL; k++) begin
      int i;
      i = lane_i(k);
      if (k < 32)      bus.SAD4x8[i*13 +: 13]   = in_sad[k][12:0];
      else if (k < 64) bus.SAD8x4[i*13 +: 13]   = in_sad[k][12:0];
      else if (k < 80) bus.SAD8x8[i*14 +: 14]   = in_sad[k][13:0];
      else if (k < 88) bus.SAD8x16[i*15 +: 15]  = in_sad[k][14:0];
      else if (k < 96) bus.SAD16x8[i*15 +: 15]  = in_sad[k][14:0];
      else             bus.SAD16x16[i*16 +: 16] = in_sad[k];
    end
  endtask

  task automatic rand_sads(int maxv);
    for (int k = 0; k < NL; k++) in_sad[k] = 16'($urandom_range(0, maxv)) & all_ones(k);
  endtask

  task automatic model_reset();
    exp_state = S_IDLE;
    hist_n = 0;
    for (int k = 0; k < NL; k++) begin
      exp_sad[k] = all_ones(k);
      exp_mv[k]  = '0;
    end
  endtask

  // Expected result is the first candidate of the window achieving each lane's minimum.
  task automatic recompute();
    for (int k = 0; k < NL; k++) begin
      int best;
      best = 0;
      for (int j = 1; j < hist_n; j++) if (hist_sad[j][k] < hist_sad[best][k]) best = j;
      exp_sad[k] = hist_sad[best][k];
      exp_mv[k]  = hist_mv[best];
    end
  endtask

  task automatic model_clock(bit start, bit valid, bit rready, logic [2*MVW-1:0] mv);
    case (exp_state)
      S_IDLE: if (start) begin
        exp_state = S_SEARCH;
        hist_n = 0;
      end
      S_SEARCH: if (valid) begin
        for (int k = 0; k < NL; k++) hist_sad[hist_n][k] = in_sad[k];
        hist_mv[hist_n] = mv;
        hist_n++;
        recompute();
        if (hist_n == NC) exp_state = S_DONE;
      end
      default: if (rready) exp_state = S_IDLE;
    endcase
  endtask

  task automatic apply_stimulus(bit start, bit valid, bit rready, logic [MVW-1:0] mvx, logic [MVW-1:0] mvy);
    @(negedge clk);
    bus.cu_start   = start;
    bus.cand_valid = valid;
    bus.res_ready  = rready;
    bus.cand_mv_x  = mvx;
    bus.cand_mv_y  = mvy;
    drive_sads();
    @(posedge clk);
    model_clock(start, valid, rready, {mvy, mvx});
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_output(string tag, bit lanes);
    chk({tag, ":cand_ready"}, 32'(bus.cand_ready), 32'(exp_state == S_SEARCH));
    chk({tag, ":res_valid"},  32'(bus.res_valid),  32'(exp_state == S_DONE));
    if (lanes) begin
      for (int k = 0; k < NL; k++) begin
        chk($sformatf("%s:sad[%0d]", tag, k), 32'(obs_sad(k)), 32'(exp_sad[k]));
        chk($sformatf("%s:mv[%0d]", tag, k),  32'(obs_mv(k)),  32'(exp_mv[k]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    bus.cu_start = 1'b0; bus.cand_valid = 1'b1; bus.res_ready = 1'b0;
    bus.cand_mv_x = '0; bus.cand_mv_y = '0;
    for (int k = 0; k < NL; k++) in_sad[k] = '0;
    drive_sads();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hold", 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] idle with cand_valid high and no cu_start");
    for (int c = 0; c < 3; c++) begin
      rand_sads(8191);
      apply_stimulus(1'b0, 1'b1, 1'b0, 6'd5, 6'd7);
      check_output("idle", 1'b1);
    end

    $display("[TB] monotone search");
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
    check_output("mono_start", 1'b0);
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < NL; k++) in_sad[k] = 16'(mono_sad[j]);
      apply_stimulus(1'b0, 1'b1, 1'b0, mono_x[j], mono_y[j]);
      check_output($sformatf("mono%0d", j), j == 3);
    end
    chk("mono_res_valid", 32'(bus.res_valid), 32'd1);
    chk("mono_sad_l0",  32'(obs_sad(0)),  32'd80);
    chk("mono_mv_l0",   32'(obs_mv(0)),   32'hFC1);
    chk("mono_sad_l99", 32'(obs_sad(99)), 32'd80);
    chk("mono_mv_l99",  32'(obs_mv(99)),  32'hFC1);
    apply_stimulus(1'b0, 1'b0, 1'b1, '0, '0);
    check_output("mono_release", 1'b0);

    $display("[TB] independent lanes");
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < NL; k++) in_sad[k] = 16'($urandom_range(20, 200));
      if (j == 1) in_sad[5] = 16'd7;
      if (j == 2) in_sad[99] = 16'd9;
      rx = MVW'($urandom); ry = MVW'($urandom);
      if (j == 1) mv_c2 = {ry, rx};
      if (j == 2) mv_c3 = {ry, rx};
      apply_stimulus(1'b0, 1'b1, 1'b0, rx, ry);
      check_output($sformatf("indep%0d", j), 1'b1);
    end
    chk("indep_sad_4x8_l5",   32'(obs_sad(5)),  32'd7);
    chk("indep_mv_4x8_l5",    32'(obs_mv(5)),   32'(mv_c2));
    chk("indep_sad_16x16_l3", 32'(obs_sad(99)), 32'd9);
    chk("indep_mv_16x16_l3",  32'(obs_mv(99)),  32'(mv_c3));

    $display("[TB] back-pressure in DONE");
    for (int c = 0; c < 10; c++) begin
      rand_sads(3);
      apply_stimulus(c % 3 == 0, 1'b1, 1'b0, MVW'($urandom), MVW'($urandom));
      check_output("bp_hold", 1'b1);
    end
    chk("bp_sad_4x8_l5", 32'(obs_sad(5)), 32'd7);
    apply_stimulus(1'b1, 1'b1, 1'b1, '0, '0);
    check_output("bp_release", 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, '0, '0);
    check_output("bp_start_ignored", 1'b0);

    $display("[TB] gapped random windows");
    for (int cu = 0; cu < 6; cu++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        rand_sads(8191);
        apply_stimulus(1'b0, 1'($urandom), 1'b0, MVW'($urandom), MVW'($urandom));
        check_output("gap_idle", 1'b0);
      end
      apply_stimulus(1'b1, 1'($urandom), 1'b0, MVW'($urandom), MVW'($urandom));
      check_output("gap_start", 1'b1);
      guard = 0;
      while (exp_state == S_SEARCH && guard < 100) begin
        rand_sads((cu % 2 == 0) ? 15 : 8191);
        apply_stimulus(1'b0, $urandom_range(0, 2) != 0, 1'b0, MVW'($urandom), MVW'($urandom));
        check_output("gap_search", 1'b1);
        guard++;
      end
      apply_stimulus(1'b0, 1'b0, 1'b1, '0, '0);
      check_output("gap_release", 1'b1);
    end

    $display("[TB] asynchronous reset mid-search");
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
    for (int j = 0; j < 2; j++) begin
      rand_sads(8191);
      apply_stimulus(1'b0, 1'b1, 1'b0, MVW'($urandom), MVW'($urandom));
    end
    check_output("pre_reset", 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("async_reset", 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
    for (int j = 0; j < NC; j++) begin
      rand_sads(8191);
      apply_stimulus(1'b0, 1'b1, 1'b0, MVW'($urandom), MVW'($urandom));
      check_output($sformatf("post_reset%0d", j), 1'b1);
    end
    apply_stimulus(1'b0, 1'b0, 1'b1, '0, '0);
    check_output("post_reset_release", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
